// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages with alternating grant and timeout abort
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  output logic        if_err_o,
  output logic        if_stall_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_rw_i,
  output logic [31:0] d_rdata_o,
  output logic        d_valid_o,
  output logic        d_err_o,
  output logic        d_stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_rw_o,
  output logic        mem_we_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  localparam logic [1:0] IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_D = 2'd2;
  localparam logic [3:0] RW_FETCH = 4'b1010;
  logic [1:0] state;
  logic last_d;
  logic [CW-1:0] cnt;
  logic if_elig, d_elig, gnt_d, gnt_if, expire, d_store;
  always_comb begin
    if_elig = if_req_i & ~if_valid_o;
    d_elig = d_req_i & d_rw_i[3] & ~d_valid_o;
    gnt_d = d_elig & (~if_elig | ~last_d);
    gnt_if = if_elig & ~gnt_d;
    expire = (TIMEOUT != 0) && (cnt == TO);
    d_store = (d_rw_i[1] & d_rw_i[0]) | (d_rw_i[2] & d_rw_i[1]);
  end
  assign if_stall_o = if_req_i & ~if_valid_o;
  assign d_stall_o = d_req_i & d_rw_i[3] & ~d_valid_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last_d <= 1'b0;
      cnt <= '0;
      if_rdata_o <= '0;
      if_valid_o <= 1'b0;
      if_err_o <= 1'b0;
      d_rdata_o <= '0;
      d_valid_o <= 1'b0;
      d_err_o <= 1'b0;
      mem_req_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      mem_rw_o <= '0;
      mem_we_o <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      if_err_o <= 1'b0;
      d_valid_o <= 1'b0;
      d_err_o <= 1'b0;
      if (state == IDLE) begin
        if (gnt_d | gnt_if) begin
          state <= gnt_d ? BUSY_D : BUSY_IF;
          cnt <= '0;
          mem_req_o <= 1'b1;
          mem_addr_o <= gnt_d ? d_addr_i : if_addr_i;
          mem_wdata_o <= gnt_d ? d_wdata_i : '0;
          mem_rw_o <= gnt_d ? d_rw_i : RW_FETCH;
          mem_we_o <= gnt_d & d_store;
        end
      end else if (mem_ready_i | expire) begin
        // ready wins over a coincident timeout, so err is simply ~ready here
        state <= IDLE;
        cnt <= '0;
        mem_req_o <= 1'b0;
        if (mem_ready_i) last_d <= state == BUSY_D;
        if (state == BUSY_IF) begin
          if_valid_o <= 1'b1;
          if_err_o <= ~mem_ready_i;
          if_rdata_o <= mem_ready_i ? mem_rdata_i : '0;
        end else begin
          d_valid_o <= 1'b1;
          d_err_o <= ~mem_ready_i;
          if (~mem_ready_i | ~mem_we_o) d_rdata_o <= mem_ready_i ? mem_rdata_i : '0;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus checked every cycle against a transaction-level model, plus literal expectations
module tb_mem_port_arbiter;
  localparam int TO = 4;
  localparam int NONE = 0, IFW = 1, DW = 2;
  logic clk = 0;
  logic rst_i = 1;
  logic if_req_i = 0, d_req_i = 0, mem_ready_i = 0;
  logic [31:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0, mem_rdata_i = '0;
  logic [3:0] d_rw_i = '0;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic if_valid_o, if_err_o, if_stall_o, d_valid_o, d_err_o, d_stall_o, mem_req_o, mem_we_o;
  logic [3:0] mem_rw_o;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_valid_o(if_valid_o), .if_err_o(if_err_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_rw_i(d_rw_i),
    .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .d_err_o(d_err_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rw_o(mem_rw_o), .mem_we_o(mem_we_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Model: one outstanding transaction, owner and age in cycles of mem_req
  int m_owner = NONE, m_last = IFW, m_age = 0;
  logic e_req = 0, e_we = 0, e_if_valid = 0, e_if_err = 0, e_d_valid = 0, e_d_err = 0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;
  logic [3:0] e_rw = '0;

  function automatic int pick();
    bit f = if_req_i && !e_if_valid;
    bit d = d_req_i && d_rw_i[3] && !e_d_valid;
    if (f && d) return (m_last == IFW) ? DW : IFW;
    return d ? DW : (f ? IFW : NONE);
  endfunction

  function automatic bit is_store(input logic [3:0] rw);
    return rw inside {4'b1011, 4'b1110, 4'b1111};
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      m_owner <= NONE; m_last <= IFW; m_age <= 0;
      e_req <= 0; e_we <= 0; e_addr <= '0; e_wdata <= '0; e_rw <= '0;
      e_if_valid <= 0; e_if_err <= 0; e_d_valid <= 0; e_d_err <= 0;
      e_if_rdata <= '0; e_d_rdata <= '0;
    end else begin
      e_if_valid <= 0; e_if_err <= 0; e_d_valid <= 0; e_d_err <= 0;
      if (m_owner == NONE) begin
        case (pick())
          IFW: begin
            m_owner <= IFW; m_age <= 1; e_req <= 1;
            e_addr <= if_addr_i; e_wdata <= '0; e_rw <= 4'b1010; e_we <= 0;
          end
          DW: begin
            m_owner <= DW; m_age <= 1; e_req <= 1;
            e_addr <= d_addr_i; e_wdata <= d_wdata_i; e_rw <= d_rw_i; e_we <= is_store(d_rw_i);
          end
          default: ;
        endcase
      end else if (mem_ready_i || (TO != 0 && m_age == TO + 1)) begin
        m_owner <= NONE; e_req <= 0;
        if (mem_ready_i) m_last <= m_owner;
        if (m_owner == IFW) begin
          e_if_valid <= 1; e_if_err <= !mem_ready_i;
          e_if_rdata <= mem_ready_i ? mem_rdata_i : '0;
        end else begin
          e_d_valid <= 1; e_d_err <= !mem_ready_i;
          if (!mem_ready_i) e_d_rdata <= '0;
          else if (!e_we) e_d_rdata <= mem_rdata_i;
        end
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", 32'(mem_req_o), 32'(e_req));
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_wdata", mem_wdata_o, e_wdata);
      chk("mem_rw", 32'(mem_rw_o), 32'(e_rw));
      chk("mem_we", 32'(mem_we_o), 32'(e_we));
      chk("if_valid", 32'(if_valid_o), 32'(e_if_valid));
      chk("if_err", 32'(if_err_o), 32'(e_if_err));
      chk("if_rdata", if_rdata_o, e_if_rdata);
      chk("d_valid", 32'(d_valid_o), 32'(e_d_valid));
      chk("d_err", 32'(d_err_o), 32'(e_d_err));
      chk("d_rdata", d_rdata_o, e_d_rdata);
      chk("if_stall", 32'(if_stall_o), 32'(if_req_i & ~e_if_valid));
      chk("d_stall", 32'(d_stall_o), 32'(d_req_i & d_rw_i[3] & ~e_d_valid));
    end
  end

  task automatic serve(input int k, input logic [31:0] rd);
    int n = 0;
    while (!mem_req_o && n < 20) begin tick(); n++; end
    if (!mem_req_o) chk("serve_wait_req", 32'(mem_req_o), 32'd1);
    repeat (k) tick();
    mem_ready_i = 1; mem_rdata_i = rd;
    tick();
    mem_ready_i = 0; mem_rdata_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gq[$];
    int cq[$];
    int cnt;
    bit prev, seen, any;
    tick();
    chk_en = 1;
    tick(); tick();
    rst_i = 0;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_d_rdata", d_rdata_o, 32'd0);
    chk("rst_if_valid", 32'(if_valid_o), 32'd0);

    // simultaneous after reset: data wins, store leaves d_rdata alone
    if_req_i = 1; if_addr_i = 32'h100;
    d_req_i = 1; d_rw_i = 4'b1111; d_addr_i = 32'h2000; d_wdata_i = 32'hDEADBEEF;
    tick();
    chk("tie_addr", mem_addr_o, 32'h2000);
    chk("tie_we", 32'(mem_we_o), 32'd1);
    chk("tie_wdata", mem_wdata_o, 32'hDEADBEEF);
    serve(0, 32'h5555_5555);
    chk("st_valid", 32'(d_valid_o), 32'd1);
    chk("st_rdata", d_rdata_o, 32'd0);
    d_req_i = 0; d_rw_i = 4'b0000;
    tick();
    chk("tie2_addr", mem_addr_o, 32'h100);
    chk("tie2_rw", 32'(mem_rw_o), 32'b1010);
    serve(1, 32'h93);
    chk("tie2_rdata", if_rdata_o, 32'h93);
    if_req_i = 0;
    tick();

    // fetch only, ready two cycles after mem_req rises
    if_req_i = 1; if_addr_i = 32'h100;
    tick();
    chk("f_rw", 32'(mem_rw_o), 32'b1010);
    chk("f_we", 32'(mem_we_o), 32'd0);
    chk("f_stall", 32'(if_stall_o), 32'd1);
    serve(2, 32'h13);
    chk("f_valid", 32'(if_valid_o), 32'd1);
    chk("f_rdata", if_rdata_o, 32'h13);
    chk("f_stall_end", 32'(if_stall_o), 32'd0);
    if_req_i = 0;
    tick();

    // fair alternation with ready one cycle after request
    if_req_i = 1; if_addr_i = 32'h400;
    d_req_i = 1; d_rw_i = 4'b1010; d_addr_i = 32'h500;
    prev = 0; seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (mem_req_o && !prev) begin gq.push_back(mem_addr_o); cq.push_back(c); end
      prev = mem_req_o;
      mem_ready_i = mem_req_o && seen;
      mem_rdata_i = mem_addr_o ^ 32'hA5A5_0000;
      seen = mem_req_o;
      tick();
    end
    if_req_i = 0; d_req_i = 0; mem_ready_i = 0; mem_rdata_i = '0;
    chk("alt_count", 32'(gq.size()), 32'd5);
    if (gq.size() >= 4) begin
      chk("alt_g0", gq[0], 32'h500);
      chk("alt_g1", gq[1], 32'h400);
      chk("alt_g2", gq[2], 32'h500);
      chk("alt_g3", gq[3], 32'h400);
      chk("alt_gap", 32'(cq[3] - cq[2]), 32'd3);
    end
    tick(); tick();

    // timeout of a load: req high TO+1 cycles, rdata cleared
    d_req_i = 1; d_rw_i = 4'b1010; d_addr_i = 32'h3000;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req_o) cnt++;
      if (d_valid_o) break;
    end
    chk("to_req_cycles", 32'(cnt), 32'd5);
    chk("to_valid", 32'(d_valid_o), 32'd1);
    chk("to_err", 32'(d_err_o), 32'd1);
    chk("to_rdata", d_rdata_o, 32'd0);
    d_req_i = 0;
    tick();

    // ready coinciding with the timeout cycle completes normally
    if_req_i = 1; if_addr_i = 32'h600;
    tick();
    serve(4, 32'h77);
    chk("rt_valid", 32'(if_valid_o), 32'd1);
    chk("rt_err", 32'(if_err_o), 32'd0);
    chk("rt_rdata", if_rdata_o, 32'h77);
    if_req_i = 0;
    tick();
    mem_ready_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    mem_ready_i = 0; mem_rdata_i = '0;
    chk("late_rdy_rdata", if_rdata_o, 32'h77);
    chk("late_rdy_req", 32'(mem_req_o), 32'd0);
    tick();

    // invalid data code never reaches memory
    d_req_i = 1; d_rw_i = 4'b0000; d_addr_i = 32'h7000;
    #1;
    chk("inv_stall", 32'(d_stall_o), 32'd0);
    any = 0;
    repeat (6) begin tick(); any |= mem_req_o; end
    chk("inv_req", 32'(any), 32'd0);
    d_req_i = 0;
    tick();

    // reset during a fetch, then a fresh fetch
    if_req_i = 1; if_addr_i = 32'h800;
    tick();
    chk("rm_req_up", 32'(mem_req_o), 32'd1);
    rst_i = 1;
    tick();
    chk("rm_req_down", 32'(mem_req_o), 32'd0);
    chk("rm_no_valid", 32'(if_valid_o), 32'd0);
    rst_i = 0;
    tick();
    serve(1, 32'h99);
    chk("rm_valid", 32'(if_valid_o), 32'd1);
    chk("rm_rdata", if_rdata_o, 32'h99);
    if_req_i = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
